// File: rtl/pds_ctrl.sv
// pds_ctrl: request/grant controller feeding the PDS interface.
// Sequence: programmable grant delay, optional maximum-hold timeout,
// post-grant cool-down, sticky fault lock-out cleared by software.
//
// Optional feature macro: PDS_CTRL_TIMEOUT_EN
//   defined     -> hold counter and maximum-hold timeout are built in
//   not defined -> GRANT lasts until req=0 or fault, timeout_sticky tied 0
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   req            in   request, level
//   fault          in   fault indication, level
//   clr_fault      in   single-cycle clear of sticky flags
//   gnt            out  grant, registered
//   state          out  FSM state: IDLE=0 WAIT=1 GRANT=2 COOL=3 FAULT=4
//   fault_sticky   out  set on fault entry, cleared on fault exit
//   timeout_sticky out  set on hold timeout, cleared by clr_fault
//   gnt_cnt        out  saturating count of grants issued
module pds_ctrl #(
  parameter int unsigned GNT_DLY  = 2,
  parameter int unsigned COOL_CYC = 1,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             fault,
  input  logic             clr_fault,
  output logic             gnt,
  output logic [2:0]       state,
  output logic             fault_sticky,
  output logic             timeout_sticky,
  output logic [CNT_W-1:0] gnt_cnt
);

  localparam int unsigned DLY_W  = (GNT_DLY > 1) ? $clog2(GNT_DLY) : 1;
  localparam int unsigned COOL_W = (COOL_CYC > 1) ? $clog2(COOL_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_GRANT = 3'd2,
    ST_COOL  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  // Elaboration-time parameter sanity check.
  if (MAX_HOLD == 0 || CNT_W == 0) begin : g_param_chk
    $error("pds_ctrl: MAX_HOLD and CNT_W must be at least 1");
  end

  state_e             state_q, state_d;
  logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic [COOL_W-1:0]  cool_cnt_q, cool_cnt_d;
  logic [CNT_W-1:0]   gnt_cnt_q, gnt_cnt_d;
  logic               gnt_q, gnt_d;
  logic               fault_sticky_q, fault_sticky_d;
  logic               go_cool;
`ifdef PDS_CTRL_TIMEOUT_EN
  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               timeout_sticky_q, timeout_sticky_d;
  logic               timeout_hit;
`endif

  // Next-state, counter and flag logic; priority fault > release > timeout > expiry.
  always_comb begin
    state_d        = state_q;
    dly_cnt_d      = dly_cnt_q;
    cool_cnt_d     = cool_cnt_q;
    gnt_cnt_d      = gnt_cnt_q;
    fault_sticky_d = fault_sticky_q;
    go_cool        = 1'b0;
`ifdef PDS_CTRL_TIMEOUT_EN
    hold_cnt_d       = hold_cnt_q;
    timeout_sticky_d = timeout_sticky_q;
    timeout_hit      = 1'b0;
`endif

    if (fault) begin
      state_d        = ST_FAULT;
      fault_sticky_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (GNT_DLY == 0) begin
              state_d = ST_GRANT;
            end else begin
              state_d   = ST_WAIT;
              dly_cnt_d = DLY_W'(GNT_DLY - 1);
            end
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state_d = ST_IDLE;
          end else if (dly_cnt_q == '0) begin
            state_d = ST_GRANT;
          end else begin
            dly_cnt_d = dly_cnt_q - DLY_W'(1);
          end
        end
        ST_GRANT: begin
          if (!req) begin
            go_cool = 1'b1;
`ifdef PDS_CTRL_TIMEOUT_EN
          end else if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
            go_cool     = 1'b1;
            timeout_hit = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
          end
        end
        ST_COOL: begin
          // req is deliberately ignored while cooling down
          if (cool_cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cool_cnt_d = cool_cnt_q - COOL_W'(1);
          end
        end
        ST_FAULT: begin
          if (clr_fault) begin
            go_cool        = 1'b1;
            fault_sticky_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A zero-length cool-down skips COOL and returns straight to IDLE.
    if (go_cool) begin
      if (COOL_CYC == 0) begin
        state_d = ST_IDLE;
      end else begin
        state_d    = ST_COOL;
        cool_cnt_d = COOL_W'(COOL_CYC - 1);
      end
    end

    if (state_d == ST_GRANT && state_q != ST_GRANT) begin
      if (gnt_cnt_q != '1) begin
        gnt_cnt_d = gnt_cnt_q + CNT_W'(1);
      end
`ifdef PDS_CTRL_TIMEOUT_EN
      hold_cnt_d = '0;
`endif
    end

`ifdef PDS_CTRL_TIMEOUT_EN
    // Set wins over a same-cycle clear.
    if (clr_fault) begin
      timeout_sticky_d = 1'b0;
    end
    if (timeout_hit) begin
      timeout_sticky_d = 1'b1;
    end
`endif

    gnt_d = (state_d == ST_GRANT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      dly_cnt_q      <= '0;
      cool_cnt_q     <= '0;
      gnt_cnt_q      <= '0;
      gnt_q          <= 1'b0;
      fault_sticky_q <= 1'b0;
`ifdef PDS_CTRL_TIMEOUT_EN
      hold_cnt_q       <= '0;
      timeout_sticky_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      dly_cnt_q      <= dly_cnt_d;
      cool_cnt_q     <= cool_cnt_d;
      gnt_cnt_q      <= gnt_cnt_d;
      gnt_q          <= gnt_d;
      fault_sticky_q <= fault_sticky_d;
`ifdef PDS_CTRL_TIMEOUT_EN
      hold_cnt_q       <= hold_cnt_d;
      timeout_sticky_q <= timeout_sticky_d;
`endif
    end
  end

  assign gnt          = gnt_q;
  assign state        = state_q;
  assign fault_sticky = fault_sticky_q;
  assign gnt_cnt      = gnt_cnt_q;
`ifdef PDS_CTRL_TIMEOUT_EN
  assign timeout_sticky = timeout_sticky_q;
`else
  assign timeout_sticky = 1'b0;
`endif

endmodule

// File: doc/pds_ctrl.md
# pds_ctrl

- Request/grant controller feeding the PDS interface.
- Samples `req` and `fault` on the rising edge of `clk` and drives a registered `gnt`, so all three signals are stable at the falling edge where the PDS monitor samples them.
- Sequence: programmable grant delay, optional maximum-hold timeout, post-grant cool-down, and a sticky fault lock-out that only software can clear.
- Status outputs are read by the register model through the top-level status register.

## Interface
Parameters:
- GNT_DLY, 2, cycles from accepted request to grant (0 legal)
- COOL_CYC, 1, idle cycles forced after each grant (0 legal)
- MAX_HOLD, 16, maximum grant length in cycles (>=1, used only with timeout compiled in)
- CNT_W, 8, width of grant counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req  in  1  request, level
- fault  in  1  fault indication, level
- clr_fault  in  1  single-cycle clear of sticky flags
- gnt  out  1  grant, registered
- state  out  3  FSM state: IDLE=0, WAIT=1, GRANT=2, COOL=3, FAULT=4
- fault_sticky  out  1  set on fault entry
- timeout_sticky  out  1  set on hold timeout
- gnt_cnt  out  CNT_W  saturating count of grants issued

## Operation
- Reset values: state=IDLE, gnt=0, fault_sticky=0, timeout_sticky=0, gnt_cnt=0, all internal counters 0.
- gnt is a flop equal to (next state == GRANT). No combinational path from req or fault to gnt.
- IDLE:
  - req=1, fault=0 → WAIT with dly_cnt=GNT_DLY-1.
  - If GNT_DLY=0 → directly to GRANT.
- WAIT:
  - req=0 → IDLE, no grant issued.
  - dly_cnt=0 → GRANT; otherwise decrement dly_cnt.
- GRANT:
  - hold_cnt clears on entry and increments each cycle.
  - req=0 → COOL.
  - With timeout compiled in: hold_cnt=MAX_HOLD-1 and req=1 → COOL, timeout_sticky set.
- COOL:
  - Entered with cool_cnt=COOL_CYC-1; if COOL_CYC=0 go directly to IDLE.
  - cool_cnt=0 → IDLE; otherwise decrement.
  - req is ignored in COOL.
- FAULT:
  - Entry: fault=1 sampled in any state → FAULT, fault_sticky set.
  - Exit: fault=0 and clr_fault=1 → COOL, fault_sticky cleared.
  - clr_fault while fault=1 is ignored.
- Priority, highest first: fault, req=0, timeout, counter expiry. req falling on the timeout cycle counts as a normal release; timeout_sticky is not set.
- clr_fault clears timeout_sticky in any state. Set and clear in the same cycle: set wins.
- gnt_cnt increments on every transition into GRANT and holds at 2^CNT_W-1.

## Timing
- Request to grant: req first sampled high at edge N in IDLE gives gnt high after edge N+GNT_DLY. With GNT_DLY=0, gnt goes high after edge N.
- Release: req sampled low at edge M in GRANT gives gnt low after edge M.
- Next grant: gnt can next rise after edge M+COOL_CYC+1 at the earliest (COOL exit, then IDLE accept), plus GNT_DLY.
- Fault: fault sampled at edge F drops gnt after edge F. gnt stays low until FAULT exits and the full COOL/IDLE/WAIT path completes.
- Timeout: gnt stays high for exactly MAX_HOLD cycles.
- Reset assertion mid-grant drops gnt and all outputs asynchronously. The first request after deassertion is sampled at the first rising edge.

## Configuration
- `PDS_CTRL_TIMEOUT_EN` defined: hold_cnt and the timeout transition are present and timeout_sticky is functional.
- Not defined: no hold counter, GRANT lasts until req=0 or fault, timeout_sticky tied to 0, MAX_HOLD unused.

## Test plan
- Defaults (GNT_DLY=2): req high at edge 10 → gnt high after edge 12; req low at edge 20 → gnt low after edge 20, state=COOL for 1 cycle, gnt_cnt=1.
- Fault lock-out: fault pulse at edge 15 during GRANT → gnt low after edge 15, state=4, fault_sticky=1. clr_fault at edge 18 with fault=0 → state=COOL then IDLE, fault_sticky=0. clr_fault while fault=1 → no change.
- Timeout with macro, MAX_HOLD=4, req held high → gnt high exactly 4 cycles, timeout_sticky=1, regrant after COOL+WAIT. Without macro → gnt held indefinitely, timeout_sticky=0.
- Request withdrawn in WAIT (req high 1 cycle, GNT_DLY=2) → no gnt, state returns to IDLE, gnt_cnt unchanged.
- Saturation with CNT_W=2 → 5 grants give gnt_cnt=3.
- rst_n low mid-GRANT → gnt=0 and all flags 0 immediately. GNT_DLY=0, COOL_CYC=0 back-to-back requests → gnt low exactly 1 cycle between grants.
